fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the enqueue port of a single `fifo` instance among `p_NUM_REQ` producers. It grants the port to one requester at a time and holds the grant for a burst of up to `p_MAX_BURST` words. It forwards the selected word to `enq_data`/`enq_en` and respects the FIFO's `enq_rdy` backpressure. It sits directly in front of `fifo` on the write side; the read side is not touched.

---
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO enqueue port among several producers,
// holding each grant for a burst of up to p_MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int unsigned p_WORD_LEN  = 8,
    parameter int unsigned p_NUM_REQ   = 4,
    parameter int unsigned p_MAX_BURST = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [p_NUM_REQ-1:0]            i_req,
    input  logic [p_NUM_REQ*p_WORD_LEN-1:0] i_data,
    output logic [p_NUM_REQ-1:0]            o_ack,
    output logic [p_WORD_LEN-1:0]           o_enq_data,
    output logic                            o_enq_en,
    input  logic                            i_enq_rdy,
    output logic [$clog2(p_NUM_REQ)-1:0]    o_owner,
    output logic                            o_busy
);

    localparam int unsigned OW = $clog2(p_NUM_REQ);
    localparam int unsigned BW = $clog2(p_MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic [OW-1:0]   last, last_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;

    logic [p_WORD_LEN-1:0] words [p_NUM_REQ];
    logic                  busy;
    logic                  xfer;
    logic                  release_grant;
    logic [OW-1:0]         pick_idx;

    // First set request after lst, wrapping; lst itself is considered last.
    function automatic logic [OW-1:0] pick(input logic [p_NUM_REQ-1:0] req,
                                           input logic [OW-1:0]        lst);
        logic [OW-1:0] res;
        logic          found;
        int unsigned   idx;
        res   = lst;
        found = 1'b0;
        for (int unsigned i = 1; i <= p_NUM_REQ; i++) begin
            idx = (32'(lst) + i) % p_NUM_REQ;
            if (!found && req[OW'(idx)]) begin
                res   = OW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    for (genvar k = 0; k < int'(p_NUM_REQ); k++) begin : g_words
        assign words[k] = i_data[k*p_WORD_LEN +: p_WORD_LEN];
    end

    assign busy          = (state == GRANT);
    assign xfer          = busy & i_req[owner] & i_enq_rdy;
    assign release_grant = busy & (~i_req[owner] | (xfer & (bcnt == BW'(p_MAX_BURST - 1))));
    assign pick_idx      = pick(i_req, last);

    assign o_enq_en   = xfer;
    assign o_ack      = xfer ? (p_NUM_REQ'(1) << owner) : '0;
    assign o_enq_data = busy ? words[owner] : '0;
    assign o_busy     = busy;
    assign o_owner    = owner;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            owner <= '0;
            last  <= OW'(p_NUM_REQ - 1);
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // In GRANT last equals owner, so the pick naturally scans the current owner last.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        bcnt_nxt  = bcnt;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_idx;
                    last_nxt  = pick_idx;
                    bcnt_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    if (|i_req) begin
                        owner_nxt = pick_idx;
                        last_nxt  = pick_idx;
                        bcnt_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (xfer) begin
                    bcnt_nxt = bcnt + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester sources, expected-word scoreboard
// and cycle-position checks for latency, fairness, backpressure and reset.
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  ack;
    logic [7:0]  enq_data;
    logic        enq_en;
    logic [1:0]  owner;
    logic        busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.p_WORD_LEN(8), .p_NUM_REQ(4), .p_MAX_BURST(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_data     (data),
        .o_ack      (ack),
        .o_enq_data (enq_data),
        .o_enq_en   (enq_en),
        .i_enq_rdy  (rdy),
        .o_owner    (owner),
        .o_busy     (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_scn, load_cyc, bp_cnt, stall_n;
    bit bp_arm;
    int first_by [4];
    int last_by  [4];
    logic [3:0] ack_s;
    logic [7:0] src_w [4][8];
    int src_len [4];
    int src_ptr [4];
    exp_t exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < 4; k++) begin
            req[k] = (src_ptr[k] < src_len[k]);
            data[k*8 +: 8] = (src_ptr[k] < src_len[k]) ? src_w[k][src_ptr[k]] : 8'h00;
        end
    endtask

    task automatic load(input int k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) src_w[k][i] = base + 8'(i);
        src_len[k] = n;
        src_ptr[k] = 0;
    endtask

    task automatic push(input logic [1:0] own, input logic [7:0] d);
        exp_t e;
        e.own = own;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic scn_start();
        n_scn = 0;
        load_cyc = cyc;
        for (int k = 0; k < 4; k++) begin
            first_by[k] = -1;
            last_by[k]  = -1;
        end
    endtask

    // Consume words acked at the edge just passed, then advance backpressure.
    task automatic upd();
        for (int k = 0; k < 4; k++) if (ack_s[k]) src_ptr[k]++;
        if (bp_cnt > 0) begin
            bp_cnt--;
            if (bp_cnt == 0) rdy = 1'b1;
        end else if (bp_arm && n_scn == 2 && ack_s != 4'b0) begin
            rdy = 1'b0;
            bp_cnt = 3;
            bp_arm = 1'b0;
        end
        apply();
    endtask

    task automatic sample();
        exp_t e;
        ack_s = ack;
        if (!rdy) begin
            chk("bp_en", 32'(enq_en), 0);
            chk("bp_owner", 32'(owner), 1);
            stall_n++;
        end
        if (enq_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_enq", 32'(enq_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("enq_data", 32'(enq_data), 32'(e.d));
                chk("enq_owner", 32'(owner), 32'(e.own));
                chk("enq_ack", 32'(ack), 32'(4'b0001 << e.own));
                chk("enq_busy", 32'(busy), 1);
                if (first_by[e.own] < 0) first_by[e.own] = cyc;
                last_by[e.own] = cyc;
            end
            n_scn++;
        end else begin
            chk("ack_idle", 32'(ack), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        upd();
        @(negedge clk);
        sample();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk("drain_left", 32'(exp_q.size()), 0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; rdy = 1'b1; ack_s = '0; bp_cnt = 0; bp_arm = 1'b0; stall_n = 0;
        for (int k = 0; k < 4; k++) begin src_len[k] = 0; src_ptr[k] = 0; end
        req = 4'hF; data = 32'h5A5A_5A5A;

        // Reset with all requests high
        #1 rst_n = 1'b0;
        #1;
        chk("rst_en", 32'(enq_en), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(enq_data), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_en", 32'(enq_en), 0);
        chk("rst_hold_busy", 32'(busy), 0);
        @(negedge clk);
        req = 4'h0; data = '0; rst_n = 1'b1;
        tick();
        chk("post_rst_owner", 32'(owner), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // Fairness: all four request, grant order 0,1,2,3,0
        scn_start();
        load(0, 8'h00, 8); load(1, 8'h10, 4); load(2, 8'h20, 4); load(3, 8'h30, 4);
        apply();
        for (int i = 0; i < 4; i++) push(2'd0, 8'(i));
        for (int i = 0; i < 4; i++) push(2'd1, 8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) push(2'd2, 8'h20 + 8'(i));
        for (int i = 0; i < 4; i++) push(2'd3, 8'h30 + 8'(i));
        for (int i = 4; i < 8; i++) push(2'd0, 8'(i));
        drain(100);
        chk("fair_latency", 32'(first_by[0] - load_cyc), 1);
        chk("fair_span", 32'(last_by[0] - first_by[0]), 19);
        chk("fair_count", 32'(n_scn), 20);

        // Single requester crossing a burst boundary
        scn_start();
        load(2, 8'h20, 6);
        apply();
        for (int i = 0; i < 6; i++) push(2'd2, 8'h20 + 8'(i));
        drain(50);
        chk("single_latency", 32'(first_by[2] - load_cyc), 1);
        chk("single_span", 32'(last_by[2] - first_by[2]), 5);

        // Backpressure for 3 cycles after requester 1's second word
        scn_start();
        stall_n = 0;
        bp_arm = 1'b1;
        load(1, 8'h50, 4);
        apply();
        for (int i = 0; i < 4; i++) push(2'd1, 8'h50 + 8'(i));
        drain(50);
        chk("bp_stalls", 32'(stall_n), 3);
        chk("bp_span", 32'(last_by[1] - first_by[1]), 6);
        chk("bp_count", 32'(n_scn), 4);

        // Early release by request drop, requester 3 pending
        scn_start();
        load(0, 8'h60, 2);
        apply();
        push(2'd0, 8'h60); push(2'd0, 8'h61);
        for (int i = 0; i < 3; i++) push(2'd3, 8'h70 + 8'(i));
        tick();
        load(3, 8'h70, 3);
        apply();
        drain(50);
        chk("early_gap", 32'(first_by[3] - last_by[0]), 2);
        chk("early_span3", 32'(last_by[3] - first_by[3]), 2);

        // Reset during requester 2's third word
        scn_start();
        load(2, 8'h80, 4);
        apply();
        push(2'd2, 8'h80); push(2'd2, 8'h81);
        for (int i = 0; i < 20 && n_scn < 2; i++) tick();
        chk("mid_two_words", 32'(n_scn), 2);
        @(posedge clk);
        cyc++;
        #1;
        upd();
        #1;
        chk("mid_third_en", 32'(enq_en), 1);
        chk("mid_third_data", 32'(enq_data), 32'h82);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(enq_en), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_data", 32'(enq_data), 0);
        chk("mid_rst_owner", 32'(owner), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        for (int k = 0; k < 4; k++) src_len[k] = 0;
        ack_s = '0;
        apply();
        repeat (2) tick();
        rst_n = 1'b1;
        scn_start();
        load(1, 8'h91, 1); load(2, 8'hA2, 1);
        apply();
        push(2'd1, 8'h91); push(2'd2, 8'hA2);
        drain(50);
        chk("mid_first_latency", 32'(first_by[1] - load_cyc), 1);
        chk("mid_count", 32'(n_scn), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
